// File: rtl/random_offset_gen_if.sv
// rtl/random_offset_gen_if.sv - request/seed/result bundle for random_offset_gen
interface random_offset_gen_if #(
   parameter int NUM_OF_LOGS = 30,
   parameter int OFFSET_W    = 9
);
   logic                                      start_gen;
   logic                                      seed_load;
   logic [31:0]                               seed_in;
   logic                                      busy;
   logic                                      done;
   logic [NUM_OF_LOGS-1:0][OFFSET_W-1:0]      start_offsetX;
   logic [NUM_OF_LOGS-1:0][OFFSET_W-1:0]      start_offsetY;

   modport master (
      output start_gen, seed_load, seed_in,
      input  busy, done, start_offsetX, start_offsetY
   );

   modport slave (
      input  start_gen, seed_load, seed_in,
      output busy, done, start_offsetX, start_offsetY
   );
endinterface

// File: rtl/random_offset_gen.sv
// rtl/random_offset_gen.sv - LFSR-driven generator of per-lane X/Y offsets, published atomically
module random_offset_gen #(
   parameter int          NUM_OF_LOGS = 30,
   parameter int          OFFSET_W    = 9,
   parameter int          MAX_X       = 479,
   parameter int          MAX_Y       = 479,
   parameter logic [31:0] SEED        = 32'hACE1_1F0D
) (
   input logic             CLK,
   input logic             resetN,
   random_offset_gen_if.slave bus
);

   localparam logic [31:0]         POLY     = 32'h8020_0003;
   localparam int                  IDX_W    = (NUM_OF_LOGS > 1) ? $clog2(NUM_OF_LOGS) : 1;
   localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_OF_LOGS - 1);
   localparam logic [OFFSET_W:0]   LIM_X    = (OFFSET_W+1)'(MAX_X + 1);
   localparam logic [OFFSET_W:0]   LIM_Y    = (OFFSET_W+1)'(MAX_Y + 1);

   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

   state_t                                state, state_nxt;
   logic [31:0]                           lfsr, lfsr_step;
   logic [IDX_W-1:0]                      idx;
   logic [NUM_OF_LOGS-1:0][OFFSET_W-1:0]  shadow_x, shadow_y;
   logic [NUM_OF_LOGS-1:0][OFFSET_W-1:0]  out_x, out_y;
   logic [OFFSET_W-1:0]                   fold_x, fold_y;

   // Out-of-range raws wrap once; MAX >= 2^(W-1)-1 guarantees a single subtract lands in range.
   function automatic logic [OFFSET_W-1:0] fold(input logic [OFFSET_W-1:0] raw,
                                                input logic [OFFSET_W:0]   lim);
      logic [OFFSET_W:0] wide;
      wide = {1'b0, raw};
      if (wide >= lim)
         return OFFSET_W'(wide - lim);
      return raw;
   endfunction

   assign lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? POLY : 32'h0);
   assign fold_x    = fold(lfsr[OFFSET_W-1:0], LIM_X);
   assign fold_y    = fold(lfsr[2*OFFSET_W-1:OFFSET_W], LIM_Y);

   always_ff @(posedge CLK or negedge resetN) begin
      if (!resetN)
         lfsr <= SEED;
      else if (bus.seed_load)
         lfsr <= (bus.seed_in == 32'h0) ? SEED : bus.seed_in;
      else
         lfsr <= lfsr_step;
   end

   always_ff @(posedge CLK or negedge resetN) begin
      if (!resetN)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start_gen) state_nxt = FILL;
         FILL:    if (idx == LAST_IDX) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The last lane bypasses the shadow so the published set includes it on the same edge.
   always_ff @(posedge CLK or negedge resetN) begin
      if (!resetN) begin
         idx      <= '0;
         shadow_x <= '0;
         shadow_y <= '0;
         out_x    <= '0;
         out_y    <= '0;
      end else begin
         case (state)
            IDLE: if (bus.start_gen) idx <= '0;
            FILL: begin
               shadow_x[idx] <= fold_x;
               shadow_y[idx] <= fold_y;
               if (idx == LAST_IDX) begin
                  idx <= '0;
                  for (int i = 0; i < NUM_OF_LOGS; i++) begin
                     out_x[i] <= (IDX_W'(i) == idx) ? fold_x : shadow_x[i];
                     out_y[i] <= (IDX_W'(i) == idx) ? fold_y : shadow_y[i];
                  end
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy          = (state == FILL);
   assign bus.done          = (state == DONE);
   assign bus.start_offsetX = out_x;
   assign bus.start_offsetY = out_y;

endmodule

// File: doc/random_offset_gen.md
RANDOM_OFFSET_GEN -- requirements
Module: random_offset_gen

Interface
REQ-001 The module SHALL have parameter NUM_OF_LOGS, default 30, which sets the number of log lanes (offset pairs) generated.
REQ-002 The module SHALL have parameter OFFSET_W, default 9, which sets the bit width of each offset.
REQ-003 The module SHALL have parameter MAX_X, default 479, the largest legal X offset; it must satisfy 2^(OFFSET_W-1)-1 <= MAX_X <= 2^OFFSET_W-1.
REQ-004 The module SHALL have parameter MAX_Y, default 479, the largest legal Y offset, under the same constraint as MAX_X.
REQ-005 The module SHALL have parameter SEED, default 32'hACE1_1F0D, the nonzero LFSR reset and fallback seed.
REQ-006 Port CLK, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-007 Port resetN, input, 1 bit: asynchronous, active-low reset.
REQ-008 Port start_gen, input, 1 bit: single-cycle request to generate a new offset set.
REQ-009 Port seed_load, input, 1 bit: when high, loads the LFSR from seed_in.
REQ-010 Port seed_in, input, 32 bits: the seed value.
REQ-011 Port busy, output, 1 bit: high while the block is filling.
REQ-012 Port done, output, 1 bit: one-cycle pulse indicating the new set is visible.
REQ-013 Port start_offsetX, output, array [NUM_OF_LOGS-1:0] of OFFSET_W bits: X offsets per lane.
REQ-014 Port start_offsetY, output, array [NUM_OF_LOGS-1:0] of OFFSET_W bits: Y offsets per lane.

Function
REQ-015 The block SHALL contain a 32-bit Galois LFSR with polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003); it SHALL shift right and XOR the mask when the shifted-out bit is 1, on every clock, free-running.
REQ-016 When seed_load is high, the LFSR SHALL load seed_in on that edge instead of advancing; if seed_in is 0, it SHALL load SEED.
REQ-017 seed_load SHALL be honoured in every state; a fill in progress SHALL continue using the reloaded LFSR from the next edge.
REQ-018 The raw X value SHALL be lfsr[OFFSET_W-1:0]; the raw Y value SHALL be lfsr[2*OFFSET_W-1:OFFSET_W], using the pre-update LFSR value of the current cycle.
REQ-019 Fold rule: an X value SHALL be raw if raw <= MAX_X, otherwise raw-(MAX_X+1); the same rule SHALL apply to Y with MAX_Y; every output entry SHALL therefore be at most its MAX.
REQ-020 The state machine SHALL have states IDLE, FILL and DONE, and SHALL reset to IDLE.
REQ-021 IDLE with start_gen high SHALL go to FILL and set idx to 0; start_gen in FILL or DONE SHALL be ignored (no queuing).
REQ-022 Each FILL edge SHALL write the folded X/Y into shadow[idx] and increment idx.
REQ-023 When idx == NUM_OF_LOGS-1, the same edge SHALL copy the complete shadow (including the entry just written) into start_offsetX/Y, set state to DONE, and clear idx.
REQ-024 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-025 busy SHALL equal (state == FILL); done SHALL equal (state == DONE); both SHALL be driven from registered state only.
REQ-026 Latency: start_gen sampled at edge E SHALL give busy high for NUM_OF_LOGS cycles after E, outputs updated at edge E+NUM_OF_LOGS, and done high for the cycle following edge E+NUM_OF_LOGS.
REQ-027 Outputs SHALL change only at the DONE-entry edge (atomic update) and SHALL be stable at all other times; no partial set is ever visible.
REQ-028 All NUM_OF_LOGS lanes SHALL be driven, including index NUM_OF_LOGS-1.

Reset
REQ-029 While resetN is low, asynchronously: state SHALL be IDLE, idx 0, LFSR SEED, shadow and all start_offsetX/Y entries 0, busy 0, done 0.
REQ-030 Reset asserted mid-FILL SHALL abort the fill; no done SHALL follow, and outputs SHALL remain 0 until the next completed fill.
REQ-031 After resetN deasserts, the first edge SHALL behave as a normal IDLE edge.

Verification
REQ-032 Reset check: drive resetN low for 3 cycles then release -> all offsets 0, busy 0, done 0, and the LFSR sequence from SEED matches a reference model.
REQ-033 Fill timing: default parameters, start_gen at edge E -> busy high for 30 cycles, done pulse 1 cycle after edge E+30, and all 60 values equal the model with fold applied.
REQ-034 Seed handling: seed_load with seed_in=0 -> LFSR = SEED; seed_load with seed_in=32'h1234_5678 then start_gen -> offsets match the model; two runs with the same seed are identical.
REQ-035 Fold boundary: force raw X = 500 with MAX_X=479 -> lane value 20; raw 479 -> 479; raw 480 -> 0.
REQ-036 Ignored request and abort: start_gen pulsed at fill cycle 10 -> exactly one done; resetN low at fill cycle 15 -> outputs 0 and no done.
REQ-037 Parameter sweep: NUM_OF_LOGS=1, OFFSET_W=8, MAX_X=MAX_Y=200 -> busy 1 cycle, done at E+2, every value <= 200.
